// File: rtl/gb80_pkg.sv
// Shared GB80 ALU definitions: opcodes, flag bit positions, sequencer states.
// Constants only; no logic, no latency, no flow control.
package gb80_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

endpackage

// File: rtl/gb80_alu_seq_flags.sv
// Combinational Z/N/H/C assembly for one ALU pass (8-bit op, or high pass of a wide op).
// Zero latency; no flow control.
module gb80_alu_seq_flags
  import gb80_pkg::*;
#(
  parameter int OPCODE_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic [OPCODE_WIDTH-1:0] i_op,
  input  logic                    i_wide,
  input  logic [DATA_WIDTH-1:0]   i_result,
  input  logic                    i_half,
  input  logic                    i_carry,
  input  logic                    i_z_in,
  output logic [3:0]              o_flags
);

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_H] = i_half;
    o_flags[FLAG_C] = i_carry;
    if (i_wide) begin
      // 16-bit adds leave Z as the core had it
      o_flags[FLAG_Z] = i_z_in;
      o_flags[FLAG_N] = (i_op == OPCODE_WIDTH'(OP_SUB));
    end else begin
      o_flags[FLAG_Z] = (i_result == '0);
      o_flags[FLAG_N] = (i_op == OPCODE_WIDTH'(OP_SUB)) ||
                        (i_op == OPCODE_WIDTH'(OP_SBC)) ||
                        (i_op == OPCODE_WIDTH'(OP_CP));
    end
  end

endmodule

// File: rtl/gb80_alu_seq.sv
// GB80 ALU sequencer; 16-bit ADD/SUB two-pass path built only with GB80_ALU_SEQ_WIDE_EN.
// Response after 2 cycles (8-bit), 3 (wide), 1 (illegal); one request at a time, response held until i_rsp_ready.
module gb80_alu_seq
  import gb80_pkg::*;
#(
  parameter int OPCODE_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [OPCODE_WIDTH-1:0] i_req_op,
  input  logic                    i_req_wide,
  input  logic [2*DATA_WIDTH-1:0] i_req_a,
  input  logic [2*DATA_WIDTH-1:0] i_req_b,
  input  logic [3:0]              i_flags,
  output logic [DATA_WIDTH-1:0]   o_alu_a,
  output logic [DATA_WIDTH-1:0]   o_alu_b,
  output logic [OPCODE_WIDTH-1:0] o_alu_op,
  output logic                    o_alu_cin,
  input  logic [DATA_WIDTH-1:0]   i_alu_result,
  input  logic                    i_alu_half,
  input  logic                    i_alu_carry,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [2*DATA_WIDTH-1:0] o_rsp_data,
  output logic [3:0]              o_rsp_flags,
  output logic                    o_rsp_err
);

  localparam int DW = DATA_WIDTH;
`ifdef GB80_ALU_SEQ_WIDE_EN
  localparam int CW = 2 * DW;
`else
  localparam int CW = DW;
`endif

  seq_state_e              state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [CW-1:0]           a_q, a_d, b_q, b_d;
  logic                    c_q, c_d;
  logic [2*DW-1:0]         rsp_data_q, rsp_data_d;
  logic [3:0]              rsp_flags_q, rsp_flags_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    req_illegal;
  logic                    lo_is_wide;
  logic                    pass_wide;
  logic                    pass_z_in;
  logic [3:0]              pass_flags;

`ifdef GB80_ALU_SEQ_WIDE_EN
  logic          wide_q, wide_d;
  logic          z_q, z_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          carry_lo_q, carry_lo_d;

  assign req_illegal = i_req_wide &&
                       !((i_req_op == OPCODE_WIDTH'(OP_ADD)) || (i_req_op == OPCODE_WIDTH'(OP_SUB)));
  assign lo_is_wide  = wide_q;
  assign pass_wide   = (state_q == ST_HI);
  assign pass_z_in   = z_q;
`else
  logic unused_hi;
  assign unused_hi   = ^{i_req_a[2*DW-1:DW], i_req_b[2*DW-1:DW]};
  assign req_illegal = i_req_wide;
  assign lo_is_wide  = 1'b0;
  assign pass_wide   = 1'b0;
  assign pass_z_in   = 1'b0;
`endif

  gb80_alu_seq_flags #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_flags (
    .i_op    (op_q),
    .i_wide  (pass_wide),
    .i_result(i_alu_result),
    .i_half  (i_alu_half),
    .i_carry (i_alu_carry),
    .i_z_in  (pass_z_in),
    .o_flags (pass_flags)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
`ifdef GB80_ALU_SEQ_WIDE_EN
    wide_d      = wide_q;
    z_d         = z_q;
    lo_d        = lo_q;
    carry_lo_d  = carry_lo_q;
`endif
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_op    = '0;
    o_alu_cin   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          op_d = i_req_op;
          a_d  = i_req_a[CW-1:0];
          b_d  = i_req_b[CW-1:0];
          c_d  = i_flags[FLAG_C];
`ifdef GB80_ALU_SEQ_WIDE_EN
          wide_d = i_req_wide;
          z_d    = i_flags[FLAG_Z];
`endif
          if (req_illegal) begin
            rsp_data_d  = '0;
            rsp_flags_d = i_flags;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = ST_LO;
          end
        end
      end

      ST_LO: begin
        o_alu_a   = a_q[DW-1:0];
        o_alu_b   = b_q[DW-1:0];
        o_alu_op  = op_q;
        o_alu_cin = c_q;
        if (lo_is_wide) begin
`ifdef GB80_ALU_SEQ_WIDE_EN
          lo_d       = i_alu_result;
          carry_lo_d = i_alu_carry;
          state_d    = ST_HI;
`endif
        end else begin
          // CP only sets flags; the accumulator comes back untouched
          rsp_data_d  = {{DW{1'b0}},
                         (op_q == OPCODE_WIDTH'(OP_CP)) ? a_q[DW-1:0] : i_alu_result};
          rsp_flags_d = pass_flags;
          state_d     = ST_RESP;
        end
      end

      ST_HI: begin
`ifdef GB80_ALU_SEQ_WIDE_EN
        o_alu_a     = a_q[CW-1:DW];
        o_alu_b     = b_q[CW-1:DW];
        o_alu_op    = (op_q == OPCODE_WIDTH'(OP_SUB)) ? OPCODE_WIDTH'(OP_SBC) : OPCODE_WIDTH'(OP_ADC);
        o_alu_cin   = carry_lo_q;
        rsp_data_d  = {i_alu_result, lo_q};
        rsp_flags_d = pass_flags;
        state_d     = ST_RESP;
`else
        state_d     = ST_IDLE;
`endif
      end

      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef GB80_ALU_SEQ_WIDE_EN
      wide_q      <= 1'b0;
      z_q         <= 1'b0;
      lo_q        <= '0;
      carry_lo_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
`ifdef GB80_ALU_SEQ_WIDE_EN
      wide_q      <= wide_d;
      z_q         <= z_d;
      lo_q        <= lo_d;
      carry_lo_q  <= carry_lo_d;
`endif
    end
  end

  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_flags = rsp_flags_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gb80_alu_seq.sv
// Bench for gb80_alu_seq: behavioural ALU plus a 16-bit arithmetic reference for responses.
module tb_gb80_alu_seq;

`ifdef GB80_ALU_SEQ_WIDE_EN
  localparam bit WIDE_BUILD = 1'b1;
`else
  localparam bit WIDE_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [15:0] data;
    logic [3:0]  flags;
  } rsp_t;

  logic        i_clk, i_rst_n, i_req_valid, o_req_ready, i_req_wide;
  logic [2:0]  i_req_op, o_alu_op;
  logic [15:0] i_req_a, i_req_b, o_rsp_data;
  logic [3:0]  i_flags, o_rsp_flags;
  logic [7:0]  o_alu_a, o_alu_b, i_alu_result;
  logic        o_alu_cin, i_alu_half, i_alu_carry, o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic [9:0]  alu_out;

  int n_checks = 0;
  int n_fail   = 0;

  gb80_alu_seq #(.OPCODE_WIDTH(3), .DATA_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_wide(i_req_wide), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_flags(i_flags),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_cin(o_alu_cin),
    .i_alu_result(i_alu_result), .i_alu_half(i_alu_half), .i_alu_carry(i_alu_carry),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_flags(o_rsp_flags), .o_rsp_err(o_rsp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational GB80 ALU: {half, carry, result}
  function automatic logic [9:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                           input logic cin);
    int x, y, ci, r;
    logic h, c;
    logic [7:0] r8;
    x = int'(a); y = int'(b); ci = cin ? 1 : 0; r = 0; h = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin r = x + y;      h = ((x & 15) + (y & 15)) > 15;      c = r > 255; end
      3'd1: begin r = x + y + ci; h = ((x & 15) + (y & 15) + ci) > 15; c = r > 255; end
      3'd2, 3'd7: begin r = x - y; h = (x & 15) < (y & 15); c = x < y; end
      3'd3: begin r = x - y - ci; h = (x & 15) < ((y & 15) + ci); c = x < (y + ci); end
      3'd4: begin r = x & y; h = 1'b1; end
      3'd5: r = x ^ y;
      default: r = x | y;
    endcase
    r8 = 8'(r & 255);
    return {h, c, r8};
  endfunction

  always_comb alu_out = alu_model(o_alu_op, o_alu_a, o_alu_b, o_alu_cin);
  assign i_alu_half   = alu_out[9];
  assign i_alu_carry  = alu_out[8];
  assign i_alu_result = alu_out[7:0];

  // Expected response from the operation's arithmetic meaning
  function automatic rsp_t ref_rsp(input logic [2:0] op, input logic wide, input logic [15:0] a,
                                   input logic [15:0] b, input logic [3:0] fl);
    rsp_t e;
    int x, y, ci, r;
    logic [7:0] r8;
    e = '0;
    if (wide && (!WIDE_BUILD || !(op == 3'd0 || op == 3'd2))) begin
      e.err = 1'b1; e.flags = fl;
    end else if (wide) begin
      x = int'(a); y = int'(b);
      e.flags[3] = fl[3];
      if (op == 3'd0) begin
        r = x + y;
        e.flags[1] = ((x & 4095) + (y & 4095)) > 4095;
        e.flags[0] = r > 65535;
      end else begin
        r = x - y;
        e.flags[2] = 1'b1;
        e.flags[1] = (x & 4095) < (y & 4095);
        e.flags[0] = x < y;
      end
      e.data = 16'(r & 65535);
    end else begin
      x = int'(a[7:0]); y = int'(b[7:0]); ci = fl[0] ? 1 : 0; r = 0;
      case (op)
        3'd0: begin r = x + y;      e.flags[1] = ((x & 15) + (y & 15)) > 15;      e.flags[0] = r > 255; end
        3'd1: begin r = x + y + ci; e.flags[1] = ((x & 15) + (y & 15) + ci) > 15; e.flags[0] = r > 255; end
        3'd2, 3'd7: begin r = x - y; e.flags[1] = (x & 15) < (y & 15); e.flags[0] = x < y; end
        3'd3: begin r = x - y - ci; e.flags[1] = (x & 15) < ((y & 15) + ci); e.flags[0] = x < (y + ci); end
        3'd4: begin r = x & y; e.flags[1] = 1'b1; end
        3'd5: r = x ^ y;
        default: r = x | y;
      endcase
      r8 = 8'(r & 255);
      e.flags[3] = (r8 == 8'h00);
      e.flags[2] = (op == 3'd2) || (op == 3'd3) || (op == 3'd7);
      e.data = (op == 3'd7) ? {8'h00, a[7:0]} : {8'h00, r8};
    end
    return e;
  endfunction

  function automatic int exp_lat(input rsp_t e, input logic wide);
    return e.err ? 1 : (wide ? 3 : 2);
  endfunction

  task automatic drive_req(input logic [2:0] op, input logic wide, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] fl);
    i_req_op = op; i_req_wide = wide; i_req_a = a; i_req_b = b; i_flags = fl; i_req_valid = 1'b1;
  endtask

  // Issue one request, wait for the response, hold it `hold` cycles, then accept it
  task automatic run_req(input logic [2:0] op, input logic wide, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] fl, input int hold, output rsp_t got, output int lat);
    int guard;
    guard = 0;
    @(negedge i_clk);
    while (!o_req_ready && guard < 20) begin @(negedge i_clk); guard++; end
    drive_req(op, wide, a, b, fl);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 10) begin @(posedge i_clk); #1; lat++; end
    got = {o_rsp_err, o_rsp_data, o_rsp_flags};
    repeat (hold) @(posedge i_clk);
    @(negedge i_clk); i_rsp_ready = o_rsp_valid;
    @(posedge i_clk); #1; i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
    drive_req(3'd0, 1'b0, 16'h0, 16'h0, 4'h0); i_req_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_in_reset got %b want 0", o_rsp_valid); end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_req_ready); end
    n_checks++; if (o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_rsp_valid); end
    n_checks++; if ({o_rsp_err, o_rsp_data, o_rsp_flags} !== 21'h0) begin n_fail++;
      $display("FAIL reset_rsp got err=%b data=%h flags=%b want all 0", o_rsp_err, o_rsp_data, o_rsp_flags); end
    n_checks++; if ({o_alu_a, o_alu_b, o_alu_op, o_alu_cin} !== 20'h0) begin n_fail++;
      $display("FAIL reset_alu got a=%h b=%h op=%0d cin=%b want all 0", o_alu_a, o_alu_b, o_alu_op, o_alu_cin); end
  endtask

  task automatic test_directed;
    logic [2:0] ops[4] = '{3'd0, 3'd7, 3'd0, 3'd4};
    logic       wds[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] as[4] = '{16'h003A, 16'h003C, 16'h8A23, 16'h1234};
    logic [15:0] bs[4] = '{16'h00C6, 16'h0040, 16'h0605, 16'h00FF};
    logic [3:0]  fs[4] = '{4'b0000, 4'b0001, 4'b1000, 4'b0110};
    rsp_t got, e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      e = ref_rsp(ops[i], wds[i], as[i], bs[i], fs[i]);
      run_req(ops[i], wds[i], as[i], bs[i], fs[i], 0, got, lat);
      n_checks++; if (got !== e) begin n_fail++;
        $display("FAIL directed_%0d_rsp got err=%b data=%h flags=%b want err=%b data=%h flags=%b",
                 i, got.err, got.data, got.flags, e.err, e.data, e.flags); end
      n_checks++; if (lat !== exp_lat(e, wds[i])) begin n_fail++;
        $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, exp_lat(e, wds[i])); end
    end
  endtask

  task automatic test_wide_hi;
`ifdef GB80_ALU_SEQ_WIDE_EN
    @(negedge i_clk);
    drive_req(3'd0, 1'b1, 16'h8A23, 16'h0605, 4'b1000);
    @(posedge i_clk); #1; i_req_valid = 1'b0;
    n_checks++; if ({o_alu_op, o_alu_a, o_alu_b} !== {3'd0, 8'h23, 8'h05}) begin n_fail++;
      $display("FAIL wide_lo_pass got op=%0d a=%h b=%h want op=0 a=23 b=05", o_alu_op, o_alu_a, o_alu_b); end
    @(posedge i_clk); #1;
    n_checks++; if ({o_alu_op, o_alu_cin, o_alu_a, o_alu_b} !== {3'd1, 1'b0, 8'h8A, 8'h06}) begin n_fail++;
      $display("FAIL wide_hi_pass got op=%0d cin=%b a=%h b=%h want op=1 cin=0 a=8a b=06",
               o_alu_op, o_alu_cin, o_alu_a, o_alu_b); end
    @(posedge i_clk); #1;
    n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_flags, o_alu_op} !== {1'b1, 16'h9028, 4'b1010, 3'd0}) begin n_fail++;
      $display("FAIL wide_hi_result got valid=%b data=%h flags=%b aluop=%0d want 1 9028 1010 0",
               o_rsp_valid, o_rsp_data, o_rsp_flags, o_alu_op); end
    @(negedge i_clk); i_rsp_ready = 1'b1;
    @(posedge i_clk); #1; i_rsp_ready = 1'b0;
`endif
  endtask

  task automatic test_backpressure;
    rsp_t e1, e2;
    int lat;
    e1 = ref_rsp(3'd1, 1'b0, 16'h0012, 16'h00F0, 4'b0001);
    e2 = ref_rsp(3'd6, 1'b0, 16'h000F, 16'h0030, 4'b0001);
    @(negedge i_clk);
    drive_req(3'd1, 1'b0, 16'h0012, 16'h00F0, 4'b0001);
    @(posedge i_clk); #1;
    drive_req(3'd6, 1'b0, 16'h000F, 16'h0030, 4'b0001);
    lat = 1;
    while (!o_rsp_valid && lat < 10) begin @(posedge i_clk); #1; lat++; end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got %0d want 2", lat); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if ({o_rsp_valid, o_req_ready, o_rsp_err, o_rsp_data, o_rsp_flags} !== {1'b1, 1'b0, e1}) begin n_fail++;
        $display("FAIL bp_hold_%0d got valid=%b ready=%b err=%b data=%h flags=%b want 1 0 %b %h %b",
                 k, o_rsp_valid, o_req_ready, o_rsp_err, o_rsp_data, o_rsp_flags, e1.err, e1.data, e1.flags); end
      @(posedge i_clk); #1;
    end
    @(negedge i_clk); i_rsp_ready = 1'b1;
    @(posedge i_clk); #1; i_rsp_ready = 1'b0;
    n_checks++; if ({o_req_ready, o_rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL bp_after_handshake got ready=%b valid=%b want 1 0", o_req_ready, o_rsp_valid); end
    @(posedge i_clk); #1; i_req_valid = 1'b0;
    n_checks++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got ready=%b want 0", o_req_ready); end
    lat = 1;
    while (!o_rsp_valid && lat < 10) begin @(posedge i_clk); #1; lat++; end
    n_checks++; if ({o_rsp_err, o_rsp_data, o_rsp_flags} !== e2) begin n_fail++;
      $display("FAIL bp_second_rsp got data=%h flags=%b want data=%h flags=%b", o_rsp_data, o_rsp_flags, e2.data, e2.flags); end
    @(negedge i_clk); i_rsp_ready = 1'b1;
    @(posedge i_clk); #1; i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    rsp_t got;
    int lat;
    @(negedge i_clk);
    drive_req(3'd0, 1'b1, 16'h8A23, 16'h0605, 4'b1000);
    @(posedge i_clk); #1; i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0; #1;
    n_checks++; if ({o_rsp_valid, o_rsp_err, o_rsp_data, o_alu_op} !== 21'h0) begin n_fail++;
      $display("FAIL midrst_abort got valid=%b err=%b data=%h aluop=%0d want all 0", o_rsp_valid, o_rsp_err, o_rsp_data, o_alu_op); end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++; if ({o_req_ready, o_rsp_valid} !== 2'b10) begin n_fail++;
      $display("FAIL midrst_idle got ready=%b valid=%b want 1 0", o_req_ready, o_rsp_valid); end
    run_req(3'd6, 1'b0, 16'h00F0, 16'h000F, 4'b0000, 0, got, lat);
    n_checks++; if (got !== {1'b0, 16'h00FF, 4'b0000} || lat !== 2) begin n_fail++;
      $display("FAIL midrst_next_or got err=%b data=%h flags=%b lat=%0d want 0 00ff 0000 2", got.err, got.data, got.flags, lat); end
  endtask

  task automatic test_illegal;
    logic [2:0] ops[4] = '{3'd4, 3'd5, 3'd7, 3'd1};
    rsp_t got;
    int lat;
    logic [3:0] fl;
    for (int i = 0; i < 4; i++) begin
      fl = 4'($urandom_range(0, 15));
      run_req(ops[i], 1'b1, 16'($urandom), 16'($urandom), fl, 1, got, lat);
      n_checks++; if (got !== {1'b1, 16'h0000, fl} || lat !== 1) begin n_fail++;
        $display("FAIL illegal_%0d got err=%b data=%h flags=%b lat=%0d want 1 0000 %b 1", i, got.err, got.data, got.flags, lat, fl); end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops[4];
    logic [15:0] as[4], bs[4];
    logic [3:0]  fl;
    rsp_t        expq[$];
    int          acc_cyc[$];
    int          idx, nrsp;
    logic        acc;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 3'($urandom_range(0, 7)); as[i] = 16'($urandom_range(0, 255)); bs[i] = 16'($urandom_range(0, 255));
    end
    fl = 4'($urandom_range(0, 15));
    idx = 0; nrsp = 0;
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    drive_req(ops[0], 1'b0, as[0], bs[0], fl);
    for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
      @(negedge i_clk);
      if (o_rsp_valid && expq.size() > 0) begin
        rsp_t e;
        e = expq.pop_front();
        n_checks++; if ({o_rsp_err, o_rsp_data, o_rsp_flags} !== e) begin n_fail++;
          $display("FAIL b2b_rsp_%0d got data=%h flags=%b want data=%h flags=%b", nrsp, o_rsp_data, o_rsp_flags, e.data, e.flags); end
        nrsp++;
      end
      acc = o_req_ready && i_req_valid;
      if (acc) begin
        expq.push_back(ref_rsp(ops[idx], 1'b0, as[idx], bs[idx], fl));
        acc_cyc.push_back(cyc);
      end
      @(posedge i_clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive_req(ops[idx], 1'b0, as[idx], bs[idx], fl);
        else i_req_valid = 1'b0;
      end
    end
    i_rsp_ready = 1'b0; i_req_valid = 1'b0;
    n_checks++; if (nrsp !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", nrsp); end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      n_checks++; if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin n_fail++;
        $display("FAIL b2b_spacing_%0d got %0d want 3", k, acc_cyc[k] - acc_cyc[k-1]); end
    end
  endtask

  task automatic test_random;
    rsp_t got, e;
    int lat;
    logic [2:0] op;
    logic wide;
    logic [15:0] a, b;
    logic [3:0] fl;
    for (int i = 0; i < 40; i++) begin
      wide = ($urandom_range(0, 2) == 0);
      op   = wide ? (($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : ($urandom_range(0, 1) ? 3'd2 : 3'd0))
                  : 3'($urandom_range(0, 7));
      a = 16'($urandom); b = 16'($urandom); fl = 4'($urandom_range(0, 15));
      e = ref_rsp(op, wide, a, b, fl);
      run_req(op, wide, a, b, fl, int'($urandom_range(0, 3)), got, lat);
      n_checks++; if (got !== e || lat !== exp_lat(e, wide)) begin n_fail++;
        $display("FAIL random_%0d op=%0d wide=%b a=%h b=%h got err=%b data=%h flags=%b lat=%0d want %b %h %b %0d",
                 i, op, wide, a, b, got.err, got.data, got.flags, lat, e.err, e.data, e.flags, exp_lat(e, wide)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wide_hi();
    test_backpressure();
    test_reset_mid_op();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb80_alu_seq.md
# gb80_alu_seq

Sequencer that owns the GB80 8-bit ALU (3-bit opcode, A/B operands) and issues one- or two-pass operations to it on behalf of the core's execute stage. It accepts one request at a time over a valid/ready handshake. 8-bit ops take a single ALU pass. 16-bit ADD/SUB (e.g. ADD HL,rr) take two passes: low byte, then high byte with carry chained. It assembles the result and the Z/N/H/C flags and returns them over a valid/ready response channel.

## Interface
Parameters:
- OPCODE_WIDTH, 3, ALU opcode width
- DATA_WIDTH, 8, ALU operand width; request operands are 2*DATA_WIDTH

Ports:
- i_clk  in  1  single clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request ready, high only in IDLE
- i_req_op  in  OPCODE_WIDTH  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- i_req_wide  in  1  16-bit operation
- i_req_a, i_req_b  in  2*DATA_WIDTH  operands; 8-bit ops use [7:0]
- i_flags  in  4  current {Z,N,H,C}
- o_alu_a, o_alu_b  out  DATA_WIDTH  ALU operands
- o_alu_op  out  OPCODE_WIDTH  ALU opcode
- o_alu_cin  out  1  ALU carry/borrow in
- i_alu_result  in  DATA_WIDTH  combinational ALU result
- i_alu_half, i_alu_carry  in  1 each  ALU half-carry / carry(borrow) out
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accepted
- o_rsp_data  out  2*DATA_WIDTH  result; upper byte 0 for 8-bit ops
- o_rsp_flags  out  4  {Z,N,H,C}
- o_rsp_err  out  1  request was illegal; data 0, flags = captured i_flags

## Operation
- FSM states: IDLE, LO, HI, RESP.
- IDLE: o_req_ready=1. On i_req_valid, capture op/wide/a/b/flags and go to LO.
- Legality check at capture. Wide with op not ADD/SUB is illegal; go directly to RESP with o_rsp_err=1.
- LO: drive o_alu_a=a[7:0], o_alu_b=b[7:0], o_alu_op=op, o_alu_cin=captured C (used only by ADC/SBC). Latch result low byte, half, carry. Wide: go to HI. Otherwise: go to RESP.
- HI: drive a[15:8], b[15:8], o_alu_op=ADC for ADD or SBC for SUB, o_alu_cin=LO carry. Latch high byte, half, carry. Go to RESP.
- RESP: o_rsp_valid=1. Outputs are held stable until i_rsp_ready=1, then go to IDLE.
- 8-bit flags:
  - Z = (result==0).
  - N = op in {SUB,SBC,CP}.
  - H, C taken from the ALU.
  - CP returns o_rsp_data = captured a (A unchanged); flags as for SUB.
- Wide flags:
  - Z preserved from i_flags.
  - N = (op==SUB).
  - H, C taken from the HI pass (bit 11 / bit 15).
- o_alu_* are driven 0 in IDLE and RESP.
- Reset: state IDLE. o_rsp_valid=0, o_rsp_data=0, o_rsp_flags=0, o_rsp_err=0, o_alu_*=0, all captured registers 0. o_req_ready=1 once reset is released.
- Reset mid-operation (LO/HI/RESP) aborts: no response is issued and the captured request is discarded.

## Timing
- Request accepted at edge N.
- 8-bit: o_rsp_valid high from edge N+2.
- Wide: o_rsp_valid high from edge N+3.
- Illegal: o_rsp_valid high from edge N+1.
- Back-to-back: o_req_ready rises the cycle after the response handshake. Maximum throughput is one 8-bit op per 3 cycles.
- i_req_valid while not ready is ignored; the requester must hold its request stable.
- ALU is purely combinational; the sequencer samples i_alu_* at the end of LO/HI.

## Configuration
- GB80_ALU_SEQ_WIDE_EN defined: 16-bit ADD/SUB supported as above.
- GB80_ALU_SEQ_WIDE_EN undefined: HI state not built. Any i_req_wide=1 request is illegal (o_rsp_err=1, response at N+1). 8-bit behaviour is unchanged.

## Structure
- Shared package gb80_pkg holds:
  - ALU opcode constants (ADD..CP)
  - flag bit indices (Z=3, N=2, H=1, C=0)
  - FSM state encoding
- One sub-module, gb80_alu_seq_flags: combinational flag assembly from op, wide, result bytes, ALU half/carry and input flags.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- 8-bit ADD, a=0x3A, b=0xC6 -> data 0x0000, flags Z=1 N=0 H=1 C=1, o_rsp_valid at N+2.
- Wide ADD, a=0x8A23, b=0x0605, i_flags Z=1 -> data 0x9028, flags Z=1 N=0 H=1 C=0, o_rsp_valid at N+3, o_alu_op=ADC with o_alu_cin=0 in HI.
- CP, a=0x3C, b=0x40 -> data 0x003C, flags Z=0 N=1 H=0 C=1.
- i_rsp_ready held 0 for 5 cycles after valid:
  - data and flags stable throughout; o_req_ready=0.
  - a concurrent new request is not accepted until one cycle after the handshake.
- Reset asserted during HI of a wide ADD -> o_rsp_valid=0, state IDLE. The next 8-bit OR, a=0xF0, b=0x0F, returns 0x00FF with flags 0000.
- Wide AND (any build), and wide ADD with macro undefined -> o_rsp_err=1, data 0, flags = i_flags, o_rsp_valid at N+1.
